// File: rtl/c1_pkg.sv
// Shared types and link indices for the c1 core link arbiter family.
// Latency: none (package only).
// Backpressure: none (package only).
package c1_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } ArbState;

  // Mesh link indices as seen on the req/gnt vectors
  localparam int LINK_N = 0;
  localparam int LINK_S = 1;
  localparam int LINK_W = 2;
  localparam int LINK_E = 3;

endpackage

// File: rtl/c1_rr_pick.sv
// Round-robin priority picker: first set req bit scanning from rr_ptr upward, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the winner is consumed.
module c1_rr_pick #(
  parameter int NLINK = 4,
  parameter int IW    = (NLINK > 1) ? $clog2(NLINK) : 1
) (
  input  logic [NLINK-1:0] req,
  input  logic [IW-1:0]    rr_ptr,
  output logic [NLINK-1:0] win_oh,
  output logic [IW-1:0]    win_idx,
  output logic             win_any
);

  // Scan from farthest to nearest offset so the nearest requester overwrites the rest
  always_comb begin
    int j;
    j       = 0;
    win_oh  = '0;
    win_idx = '0;
    win_any = 1'b0;
    for (int i = NLINK - 1; i >= 0; i--) begin
      j = (int'(rr_ptr) + i) % NLINK;
      if (req[j]) begin
        win_oh    = '0;
        win_oh[j] = 1'b1;
        win_idx   = IW'(j);
        win_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/c1_link_arb.sv
// Shares the core's single IO port among the mesh links with round-robin grants and locked bursts.
// Latency: req to io_valid 1 cycle; io_ready to done/rdata 1 cycle; one beat per 2 cycles in a burst.
// Backpressure: the granted beat waits in BUSY for io_ready, aborting with err after TIMEOUT+1 cycles.
module c1_link_arb
  import c1_pkg::*;
#(
  parameter int NLINK     = 4,
  parameter int DW        = 64,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NLINK-1:0]    req,
  input  logic [NLINK-1:0]    we,
  input  logic [NLINK-1:0]    lock,
  input  logic [NLINK*DW-1:0] wdata,
  output logic [NLINK-1:0]    gnt,
  output logic [NLINK-1:0]    done,
  output logic [NLINK-1:0]    err,
  output logic [DW-1:0]       rdata,
  output logic                io_valid,
  output logic                io_we,
  output logic [DW-1:0]       io_wdata,
  input  logic                io_ready,
  input  logic [DW-1:0]       io_rdata,
  output logic                busy
);

  localparam int IW = (NLINK > 1) ? $clog2(NLINK) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] MAX_B = BW'(MAX_BURST);
  localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT);

  ArbState          state, state_d;
  logic [NLINK-1:0] gnt_d, done_d, err_d;
  logic [IW-1:0]    gidx, gidx_d;
  logic [IW-1:0]    rr_ptr, rr_d;
  logic [DW-1:0]    rdata_d;
  logic [BW-1:0]    beat_cnt, beat_d;
  logic [TW-1:0]    tmo_cnt, tmo_d;

  logic [NLINK-1:0] win_oh;
  logic [IW-1:0]    win_idx;
  logic             win_any;

  c1_rr_pick #(
    .NLINK (NLINK),
    .IW    (IW)
  ) u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .win_any (win_any)
  );

  // Core-side request: driven from the granted link only while a beat is outstanding
  always_comb begin
    io_valid = (state == BUSY);
    io_we    = io_valid & we[gidx];
    io_wdata = io_valid ? wdata[int'(gidx)*DW +: DW] : '0;
    busy     = (state != IDLE);
  end

  // Next-state and next-output logic; done/err default low so they only pulse on entry to HOLD
  always_comb begin
    state_d = state;
    gnt_d   = gnt;
    gidx_d  = gidx;
    done_d  = '0;
    err_d   = '0;
    rdata_d = rdata;
    rr_d    = rr_ptr;
    beat_d  = beat_cnt;
    tmo_d   = tmo_cnt;
    unique case (state)
      IDLE: begin
        if (win_any) begin
          gnt_d   = win_oh;
          gidx_d  = win_idx;
          state_d = BUSY;
          beat_d  = '0;
          tmo_d   = '0;
        end
      end
      BUSY: begin
        if (io_ready) begin
          rdata_d      = we[gidx] ? '0 : io_rdata;
          done_d[gidx] = 1'b1;
          state_d      = HOLD;
          beat_d       = beat_cnt + 1'b1;
        end else if (tmo_cnt == TMO_LIM) begin
          done_d[gidx] = 1'b1;
          err_d[gidx]  = 1'b1;
          rdata_d      = '0;
          state_d      = HOLD;
        end else begin
          tmo_d = tmo_cnt + 1'b1;
        end
      end
      HOLD: begin
        // A timed-out beat never continues a burst, even with lock held
        if (lock[gidx] && req[gidx] && (beat_cnt < MAX_B) && !err[gidx]) begin
          state_d = BUSY;
          tmo_d   = '0;
        end else begin
          gnt_d   = '0;
          rr_d    = IW'((int'(gidx) + 1) % NLINK);
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any in-flight beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      gidx     <= '0;
      done     <= '0;
      err      <= '0;
      rdata    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      state    <= state_d;
      gnt      <= gnt_d;
      gidx     <= gidx_d;
      done     <= done_d;
      err      <= err_d;
      rdata    <= rdata_d;
      rr_ptr   <= rr_d;
      beat_cnt <= beat_d;
      tmo_cnt  <= tmo_d;
    end
  end

endmodule

// File: tb/tb_c1_link_arb.sv
// Directed self-checking bench for c1_link_arb.
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: io_ready is driven directly by the stimulus.
module tb_c1_link_arb;
  import c1_pkg::*;

  localparam int NL  = 4;
  localparam int DW  = 64;
  localparam int MB  = 4;
  localparam int TMO = 255;

  logic             clk;
  logic             rst;
  logic [NL-1:0]    req, we, lock;
  logic [NL*DW-1:0] wdata;
  logic [NL-1:0]    gnt, done, err;
  logic [DW-1:0]    rdata;
  logic             io_valid, io_we, io_ready, busy;
  logic [DW-1:0]    io_wdata, io_rdata;

  int checks = 0;
  int errors = 0;

  c1_link_arb #(
    .NLINK     (NL),
    .DW        (DW),
    .MAX_BURST (MB),
    .TIMEOUT   (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .we       (we),
    .lock     (lock),
    .wdata    (wdata),
    .gnt      (gnt),
    .done     (done),
    .err      (err),
    .rdata    (rdata),
    .io_valid (io_valid),
    .io_we    (io_we),
    .io_wdata (io_wdata),
    .io_ready (io_ready),
    .io_rdata (io_rdata),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_oh;
    rst = 1'b1; req = '0; we = '0; lock = '0; wdata = '0;
    io_ready = 1'b0; io_rdata = '0;

    // Reset held for two cycles
    step; step;
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_valid", 64'(io_valid), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    rst = 1'b0;
    step;
    chk("post_rst_busy", 64'(busy), 64'h0);
    chk("post_rst_done", 64'(done), 64'h0);

    // Single read from link W
    req = 4'b0100; we = 4'b0000;
    step;  // cycle 1
    chk("rd_gnt", 64'(gnt), 64'h4);
    chk("rd_valid", 64'(io_valid), 64'h1);
    chk("rd_io_we", 64'(io_we), 64'h0);
    step;  // cycle 2
    chk("rd_nodone", 64'(done), 64'h0);
    step;  // cycle 3
    io_ready = 1'b1; io_rdata = 64'hDEAD_BEEF;
    step;  // cycle 4
    chk("rd_done", 64'(done), 64'h4);
    chk("rd_err", 64'(err), 64'h0);
    chk("rd_rdata", rdata, 64'hDEAD_BEEF);
    chk("rd_hold_valid", 64'(io_valid), 64'h0);
    io_ready = 1'b0; req = '0;
    step;  // cycle 5
    chk("rd_idle", 64'(busy), 64'h0);
    chk("rd_gnt_clr", 64'(gnt), 64'h0);
    chk("rd_rr_ptr", 64'(dut.rr_ptr), 64'h3);

    // Asynchronous reset in the middle of a beat
    req = 4'b0001;
    step;
    chk("ar_valid_pre", 64'(io_valid), 64'h1);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid_drop", 64'(io_valid), 64'h0);
    chk("ar_gnt_drop", 64'(gnt), 64'h0);
    #1 rst = 1'b0;
    req = '0; io_ready = 1'b1;
    step;
    chk("ar_nodone1", 64'(done), 64'h0);
    step;
    chk("ar_nodone2", 64'(done), 64'h0);
    chk("ar_idle", 64'(busy), 64'h0);

    // Round-robin with all links requesting: N,S,W,E,N, one done every 3 cycles
    req = 4'b1111; lock = '0; io_rdata = 64'hA5;
    for (int k = 0; k < 5; k++) begin
      exp_oh = 4'b0001 << (k % 4);
      step;
      chk($sformatf("rr_gnt%0d", k), 64'(gnt), 64'(exp_oh));
      chk($sformatf("rr_busy_nodone%0d", k), 64'(done), 64'h0);
      step;
      chk($sformatf("rr_done%0d", k), 64'(done), 64'(exp_oh));
      step;
      chk($sformatf("rr_idle%0d", k), 64'(gnt), 64'h0);
    end
    req = '0; io_ready = 1'b0;
    chk("rr_rdata", rdata, 64'hA5);
    chk("rr_ptr_after", 64'(dut.rr_ptr), 64'h1);

    // Timeout on link E with lock held
    req[LINK_E] = 1'b1; lock[LINK_E] = 1'b1;
    step;  // first BUSY cycle
    chk("to_gnt", 64'(gnt), 64'h8);
    for (int k = 0; k < TMO; k++) step;
    chk("to_nodone_early", 64'(done), 64'h0);
    chk("to_still_valid", 64'(io_valid), 64'h1);
    step;  // TIMEOUT+1 cycles after first BUSY cycle
    chk("to_done", 64'(done), 64'h8);
    chk("to_err", 64'(err), 64'h8);
    chk("to_rdata", rdata, 64'h0);
    step;
    chk("to_burst_end", 64'(busy), 64'h0);
    chk("to_gnt_clr", 64'(gnt), 64'h0);
    chk("to_err_clr", 64'(err), 64'h0);
    req = '0; lock = '0;

    // Locked write burst on link S: data 1..4 in one grant, 5 after re-arbitration
    req[LINK_S] = 1'b1; we[LINK_S] = 1'b1; lock[LINK_S] = 1'b1;
    wdata[LINK_S*DW +: DW] = 64'd1; io_ready = 1'b1;
    step;
    for (int b = 1; b <= MB; b++) begin
      chk($sformatf("bu_valid%0d", b), 64'(io_valid), 64'h1);
      chk($sformatf("bu_gnt%0d", b), 64'(gnt), 64'h2);
      chk($sformatf("bu_we%0d", b), 64'(io_we), 64'h1);
      chk($sformatf("bu_wdata%0d", b), io_wdata, 64'(b));
      step;
      chk($sformatf("bu_done%0d", b), 64'(done), 64'h2);
      chk($sformatf("bu_hold_gnt%0d", b), 64'(gnt), 64'h2);
      wdata[LINK_S*DW +: DW] = 64'(b + 1);
      step;
    end
    chk("bu_end_idle", 64'(busy), 64'h0);
    chk("bu_end_gnt", 64'(gnt), 64'h0);
    chk("bu_wr_rdata", rdata, 64'h0);
    step;
    chk("bu_regrant", 64'(gnt), 64'h2);
    chk("bu_wdata5", io_wdata, 64'd5);
    lock = '0;
    step;
    chk("bu_done5", 64'(done), 64'h2);
    req = '0; we = '0;
    step;
    chk("bu_final_idle", 64'(busy), 64'h0);
    chk("bu_rr_ptr", 64'(dut.rr_ptr), 64'h2);

    // Link N withdraws its request mid-beat while link S waits
    io_ready = 1'b0; io_rdata = 64'h1234;
    req = 4'b0011;
    step;
    chk("wd_gnt0", 64'(gnt), 64'h1);
    req = 4'b0010;
    step;
    chk("wd_still_busy", 64'(io_valid), 64'h1);
    chk("wd_gnt_kept", 64'(gnt), 64'h1);
    io_ready = 1'b1;
    step;
    chk("wd_done0", 64'(done), 64'h1);
    chk("wd_rdata", rdata, 64'h1234);
    step;
    chk("wd_idle", 64'(gnt), 64'h0);
    step;
    chk("wd_gnt1", 64'(gnt), 64'h2);
    step;
    chk("wd_done1", 64'(done), 64'h2);
    req = '0; io_ready = 1'b0;
    step;
    chk("wd_end_idle", 64'(busy), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
